ram_1rw_rd_resp_buf: RTL and testbench
======================================

Name: ram_1rw_rd_resp_buf

Overview:
- Request-side front end and response buffer for a single-ported, byte-masked RAM with a 2-cycle read latency (enable, address, write data and byte mask in; data out with no stall).
- Arbitrates between one write request stream and one read request stream, and drives the RAM port.
- Tracks reads in flight and captures the RAM's unstallable read data into a small FIFO.
- Presents read data to the consumer on a val/rdy interface so the consumer can apply backpressure without losing data.

Parameters:
- DATA_W, 64, RAM word width in bits; must be a multiple of 8.
- DATA_MASK_W, DATA_W/8, byte-mask width.
- DEPTH, 512, RAM depth in words.
- ADDR_W, $clog2(DEPTH), address width.
- BUF_DEPTH, 4, response FIFO entries; minimum 4, which gives full read throughput.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- wr_req_val  in  1  write request valid
- wr_req_addr  in  ADDR_W  write address
- wr_req_data  in  DATA_W  write data
- wr_req_mask  in  DATA_MASK_W  byte write enables
- wr_req_rdy  out  1  write accepted this cycle when val & rdy
- rd_req_val  in  1  read request valid
- rd_req_addr  in  ADDR_W  read address
- rd_req_rdy  out  1  read accepted this cycle when val & rdy
- ram_en  out  1  RAM port enable
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_wr_mask  out  DATA_MASK_W  RAM byte mask; all zeros for a read
- ram_dout  in  DATA_W  RAM read data, valid 2 cycles after the enable cycle
- rd_resp_val  out  1  response FIFO head valid
- rd_resp_data  out  DATA_W  response FIFO head data
- rd_resp_rdy  in  1  consumer pops the head when val & rdy

Behaviour:
- Reset (async assert, sync release):
  - Clears the in-flight valid pipe (p1, p2), the FIFO pointers and count, and the arbitration flag. The flag resets to prefer_rd=0, so writes win first.
  - Outputs: rd_resp_val=0; wr_req_rdy=rd_req_rdy=0 while rst is high, hence ram_en=0.
  - Assertion mid-operation discards all in-flight reads and buffered data; no response is emitted for them.
- Credit:
  - outstanding = p1 + p2 + fifo_count.
  - credit_ok = (outstanding < BUF_DEPTH).
  - A same-cycle pop is not credited. This conservative rule keeps the FIFO from overflowing.
- Arbitration (combinational):
  - rd_ok = rd_req_val & credit_ok.
  - If rd_ok and wr_req_val, the winner is read when prefer_rd=1, else write.
  - If only one side is eligible, that side wins.
  - Write needs no credit.
  - wr_req_rdy = ~rst & (write wins or no read eligible).
  - rd_req_rdy = ~rst & credit_ok & (read wins or ~wr_req_val).
  - prefer_rd toggles only on cycles where both rd_ok and wr_req_val were high; it then points at the loser.
- RAM drive:
  - ram_en = granted write or granted read.
  - Write grant: ram_addr/ram_din/ram_wr_mask = write fields.
  - Read grant: ram_addr = rd_req_addr, mask = 0, din = 0.
  - A write with mask 0 is legal, consumes a slot, and is not a read.
- Read tracking:
  - p1 <= read granted; p2 <= p1.
  - When p2=1, ram_dout is pushed into the FIFO that cycle.
  - Write grants never set p1; the RAM output after a write is ignored.
- Latency:
  - Read accepted in cycle t, data captured at the end of cycle t+2, rd_resp_val=1 in cycle t+3.
  - Fixed; no bypass path.
- FIFO:
  - In-order; push and pop in the same cycle are allowed, including when the count equals BUF_DEPTH-1 or BUF_DEPTH.
  - rd_resp_data = head entry; don't-care when rd_resp_val=0.
  - The head is held stable while rd_resp_val & ~rd_resp_rdy.
  - Pointers wrap modulo BUF_DEPTH.
- Throughput:
  - One read per cycle sustained when rd_resp_rdy stays high and no writes compete.
  - With rd_resp_rdy held low, at most BUF_DEPTH reads are accepted, then rd_req_rdy=0 until a pop.
- Assertions:
  - No push when fifo_count=BUF_DEPTH unless a pop occurs in the same cycle.
  - No pop when empty.
  - ram_en is never high with a nonzero mask on a read grant.

Test Plan:
- Single read: prefill addr 5 = 0xA5A5 by write, then read addr 5 at cycle t -> rd_resp_val rises in cycle t+3 with data 0xA5A5, and ram_wr_mask=0 in cycle t.
- Streaming: reads of addrs 0..15 on back-to-back cycles, rd_resp_rdy=1 -> rd_req_rdy never drops; 16 responses on consecutive cycles, in order, matching the preloaded data.
- Backpressure: rd_resp_rdy=0, read requests every cycle -> exactly 4 accepted, then rd_req_rdy=0. After rd_resp_rdy is raised, all 4 drain in order, then acceptance resumes; no data lost or duplicated.
- Contention: wr_req_val and rd_req_val held high for 6 cycles -> grants alternate W,R,W,R,W,R. A read issued after a byte-masked write to the same address (mask 0x01) returns the merged bytes.
- Reset mid-flight: 3 reads accepted, then async rst asserted between clock edges -> rd_resp_val=0 immediately and both rdy low. After release, no stale responses appear and the first new read returns correct data at t+3.
- Wrap: 50 reads with random rd_resp_rdy (50% duty) -> scoreboard match on all 50, FIFO pointers wrap multiple times, no overflow/underflow assertion fires.

Source files
------------

// File: rtl/ram_1rw_rd_resp_buf.sv
// ---------------------------------------------------------------------------
// ram_1rw_rd_resp_buf
//
// Front end for a single-ported, byte-masked RAM that has a fixed 2-cycle
// read latency and an output that cannot be stalled. One write request stream
// and one read request stream share the RAM port. Reads in flight are tracked
// in a two-stage valid pipe. Returning read data is captured into a small
// in-order FIFO, and the consumer drains that FIFO through a val/rdy handshake.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   wr_req_*             write request (val/addr/data/mask) and its rdy
//   rd_req_*             read request (val/addr) and its rdy
//   ram_en/addr/din/
//   ram_wr_mask          RAM port drive; the mask is all zeros for a read
//   ram_dout             RAM read data, valid 2 cycles after the enable cycle
//   rd_resp_val/data/rdy response FIFO head and the consumer's pop handshake
// ---------------------------------------------------------------------------
module ram_1rw_rd_resp_buf #(
    parameter int DATA_W      = 64,
    parameter int DATA_MASK_W = DATA_W / 8,
    parameter int DEPTH       = 512,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int BUF_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_req_val,
    input  logic [ADDR_W-1:0]      wr_req_addr,
    input  logic [DATA_W-1:0]      wr_req_data,
    input  logic [DATA_MASK_W-1:0] wr_req_mask,
    output logic                   wr_req_rdy,
    input  logic                   rd_req_val,
    input  logic [ADDR_W-1:0]      rd_req_addr,
    output logic                   rd_req_rdy,
    output logic                   ram_en,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [DATA_W-1:0]      ram_din,
    output logic [DATA_MASK_W-1:0] ram_wr_mask,
    input  logic [DATA_W-1:0]      ram_dout,
    output logic                   rd_resp_val,
    output logic [DATA_W-1:0]      rd_resp_data,
    input  logic                   rd_resp_rdy
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    // Wide enough to hold fifo_count plus both in-flight pipe stages.
    localparam int OUT_W = CNT_W + 2;

    localparam logic [OUT_W-1:0] BUF_DEPTH_O = OUT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(BUF_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);

    // Pointer advance with explicit wrap, so BUF_DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_ONE;
        end
        return nxt;
    endfunction

    // State
    logic                   prefer_rd_r;
    logic                   p1_r;
    logic                   p2_r;
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic                   resp_val_r;
    logic [DATA_W-1:0]      fifo_mem_r [0:BUF_DEPTH-1];

    // Combinational
    logic [OUT_W-1:0]       outstanding_s;
    logic                   credit_ok_s;
    logic                   rd_ok_s;
    logic                   contend_s;
    logic                   rd_win_s;
    logic                   wr_win_s;
    logic                   push_s;
    logic                   pop_s;
    logic [CNT_W-1:0]       count_nxt_s;
    logic [ADDR_W-1:0]      ram_addr_s;
    logic [DATA_W-1:0]      ram_din_s;
    logic [DATA_MASK_W-1:0] ram_wr_mask_s;

    // Credit check and write/read arbitration for the single RAM port.
    // A pop in the current cycle is deliberately not counted as free space.
    always_comb begin
        outstanding_s = {{(OUT_W-CNT_W){1'b0}}, count_r}
                      + {{(OUT_W-1){1'b0}}, p1_r}
                      + {{(OUT_W-1){1'b0}}, p2_r};
        credit_ok_s   = (outstanding_s < BUF_DEPTH_O);
        rd_ok_s       = rd_req_val & credit_ok_s;
        contend_s     = rd_ok_s & wr_req_val;
        if (rst) begin
            rd_win_s = 1'b0;
            wr_win_s = 1'b0;
        end else if (contend_s) begin
            rd_win_s = prefer_rd_r;
            wr_win_s = ~prefer_rd_r;
        end else begin
            rd_win_s = rd_ok_s;
            wr_win_s = wr_req_val;
        end
    end

    assign wr_req_rdy = ~rst & (wr_win_s | ~rd_ok_s);
    assign rd_req_rdy = ~rst & credit_ok_s & (rd_win_s | ~wr_req_val);

    // RAM port drive: write fields on a write grant, zero data/mask on a read.
    always_comb begin
        if (wr_win_s) begin
            ram_addr_s    = wr_req_addr;
            ram_din_s     = wr_req_data;
            ram_wr_mask_s = wr_req_mask;
        end else if (rd_win_s) begin
            ram_addr_s    = rd_req_addr;
            ram_din_s     = {DATA_W{1'b0}};
            ram_wr_mask_s = {DATA_MASK_W{1'b0}};
        end else begin
            ram_addr_s    = {ADDR_W{1'b0}};
            ram_din_s     = {DATA_W{1'b0}};
            ram_wr_mask_s = {DATA_MASK_W{1'b0}};
        end
    end

    assign ram_en      = wr_win_s | rd_win_s;
    assign ram_addr    = ram_addr_s;
    assign ram_din     = ram_din_s;
    assign ram_wr_mask = ram_wr_mask_s;

    // FIFO push comes from the end of the read pipe; pop from the consumer.
    assign push_s = p2_r;
    assign pop_s  = resp_val_r & rd_resp_rdy;

    // Next occupancy of the response FIFO.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Read-in-flight pipe and arbitration fairness flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_r        <= 1'b0;
            p2_r        <= 1'b0;
            prefer_rd_r <= 1'b0;
        end else begin
            p1_r <= rd_win_s;
            p2_r <= p1_r;
            // Flip only when both sides competed, so the loser wins next time.
            if (contend_s) begin
                prefer_rd_r <= ~prefer_rd_r;
            end else begin
                prefer_rd_r <= prefer_rd_r;
            end
        end
    end

    // Response FIFO pointers, occupancy and registered head-valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            resp_val_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r    <= count_nxt_s;
            resp_val_r <= (count_nxt_s != CNT_ZERO);
        end
    end

    // Response FIFO storage; contents are qualified by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= ram_dout;
        end
    end

    assign rd_resp_val  = resp_val_r;
    assign rd_resp_data = fifo_mem_r[rd_ptr_r];

    ram_1rw_rd_resp_buf_chk #(
        .CNT_W       (CNT_W),
        .DATA_MASK_W (DATA_MASK_W),
        .BUF_DEPTH   (BUF_DEPTH)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .push        (push_s),
        .pop         (pop_s),
        .count       (count_r),
        .rd_grant    (rd_win_s),
        .ram_en      (ram_en),
        .ram_wr_mask (ram_wr_mask_s)
    );

endmodule

// ---------------------------------------------------------------------------
// ram_1rw_rd_resp_buf_chk
//
// Protocol checks for the response buffer: no FIFO overflow, no FIFO
// underflow, and a read grant never carries a nonzero byte mask.
//
// Ports
//   clk, rst      clock and reset (checks are disabled while rst is high)
//   push, pop     FIFO push/pop strobes
//   count         FIFO occupancy
//   rd_grant      read granted to the RAM port this cycle
//   ram_en        RAM enable
//   ram_wr_mask   RAM byte mask
// ---------------------------------------------------------------------------
module ram_1rw_rd_resp_buf_chk #(
    parameter int CNT_W       = 3,
    parameter int DATA_MASK_W = 8,
    parameter int BUF_DEPTH   = 4
) (
    input logic                   clk,
    input logic                   rst,
    input logic                   push,
    input logic                   pop,
    input logic [CNT_W-1:0]       count,
    input logic                   rd_grant,
    input logic                   ram_en,
    input logic [DATA_MASK_W-1:0] ram_wr_mask
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] EMPTY = CNT_W'(0);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == FULL) && !pop));

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && (count == EMPTY)));

    a_read_mask_zero: assert property (@(posedge clk) disable iff (rst)
        !(ram_en && rd_grant && (ram_wr_mask != {DATA_MASK_W{1'b0}})));

endmodule

// File: tb/tb_ram_1rw_rd_resp_buf.sv
// ---------------------------------------------------------------------------
// tb_ram_1rw_rd_resp_buf
//
// Bench for ram_1rw_rd_resp_buf. A 2-cycle-latency byte-masked RAM model sits
// on the RAM port. A reference model samples every cycle on the falling edge.
// It predicts which request is accepted, using the queue of accepted but
// unpopped reads as the credit and a fairness flag. It also predicts when each
// response must appear at the head (accept cycle + 3) and what data it must
// carry (a shadow memory updated at write-accept time).
// ---------------------------------------------------------------------------
module tb_ram_1rw_rd_resp_buf;

    localparam int DW = 64;
    localparam int MW = 8;
    localparam int DEP = 512;
    localparam int AW = 9;
    localparam int BD = 4;

    logic          clk;
    logic          rst;
    logic          wr_req_val;
    logic [AW-1:0] wr_req_addr;
    logic [DW-1:0] wr_req_data;
    logic [MW-1:0] wr_req_mask;
    logic          wr_req_rdy;
    logic          rd_req_val;
    logic [AW-1:0] rd_req_addr;
    logic          rd_req_rdy;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [MW-1:0] ram_wr_mask;
    logic [DW-1:0] ram_dout;
    logic          rd_resp_val;
    logic [DW-1:0] rd_resp_data;
    logic          rd_resp_rdy;

    ram_1rw_rd_resp_buf #(
        .DATA_W (DW), .DATA_MASK_W (MW), .DEPTH (DEP), .ADDR_W (AW), .BUF_DEPTH (BD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_req_val   (wr_req_val),
        .wr_req_addr  (wr_req_addr),
        .wr_req_data  (wr_req_data),
        .wr_req_mask  (wr_req_mask),
        .wr_req_rdy   (wr_req_rdy),
        .rd_req_val   (rd_req_val),
        .rd_req_addr  (rd_req_addr),
        .rd_req_rdy   (rd_req_rdy),
        .ram_en       (ram_en),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_wr_mask  (ram_wr_mask),
        .ram_dout     (ram_dout),
        .rd_resp_val  (rd_resp_val),
        .rd_resp_data (rd_resp_data),
        .rd_resp_rdy  (rd_resp_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [MW-1:0] mask);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < MW; b++) begin
            if (mask[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    // RAM model: 2-cycle read latency, byte-masked write, no reset.
    logic [DW-1:0] ram_mem [0:DEP-1];
    logic [DW-1:0] ram_s1;
    always @(posedge clk) begin
        if (ram_en) begin
            ram_s1 <= ram_mem[ram_addr];
            ram_mem[ram_addr] <= merge(ram_mem[ram_addr], ram_din, ram_wr_mask);
        end
        ram_dout <= ram_s1;
    end

    // Reference model state.
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] shadow [0:DEP-1];
    logic          prefer_rd;
    int            cyc = 0;
    int            rd_fire_cnt = 0;
    int            pop_cnt = 0;
    int            acc_cyc = 0;
    int            rise_cyc = 0;
    logic          prev_val;
    logic [DW-1:0] last_pop;
    int            grant_log[$];
    int            pop_cyc_q[$];
    logic          m_rd_ok, m_exp_rd, m_exp_wr, m_exp_val, m_wr_fire, m_rd_fire;

    // Per-cycle reference check, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        m_wr_fire = wr_req_val & wr_req_rdy;
        m_rd_fire = rd_req_val & rd_req_rdy;
        if (rst) begin
            chk("rst_resp_val", {63'd0, rd_resp_val}, 64'd0);
            chk("rst_wr_rdy", {63'd0, wr_req_rdy}, 64'd0);
            chk("rst_rd_rdy", {63'd0, rd_req_rdy}, 64'd0);
            chk("rst_ram_en", {63'd0, ram_en}, 64'd0);
            exp_q.delete();
            prefer_rd = 1'b0;
            prev_val  = 1'b0;
        end else begin
            m_rd_ok   = rd_req_val && (exp_q.size() < BD);
            m_exp_rd  = m_rd_ok && (!wr_req_val || prefer_rd);
            m_exp_wr  = wr_req_val && !m_exp_rd;
            m_exp_val = (exp_q.size() != 0) && (exp_q[0].due <= cyc);
            chk("wr_grant", {63'd0, m_wr_fire}, {63'd0, m_exp_wr});
            chk("rd_grant", {63'd0, m_rd_fire}, {63'd0, m_exp_rd});
            chk("resp_val", {63'd0, rd_resp_val}, {63'd0, m_exp_val});
            if (rd_resp_val && m_exp_val) chk("resp_data", rd_resp_data, exp_q[0].data);
            if (m_rd_fire) begin
                chk("rd_ram_en", {63'd0, ram_en}, 64'd1);
                chk("rd_ram_addr", {55'd0, ram_addr}, {55'd0, rd_req_addr});
                chk("rd_ram_mask", {56'd0, ram_wr_mask}, 64'd0);
                chk("rd_ram_din", ram_din, 64'd0);
            end else if (m_wr_fire) begin
                chk("wr_ram_en", {63'd0, ram_en}, 64'd1);
                chk("wr_ram_addr", {55'd0, ram_addr}, {55'd0, wr_req_addr});
                chk("wr_ram_mask", {56'd0, ram_wr_mask}, {56'd0, wr_req_mask});
                chk("wr_ram_din", ram_din, wr_req_data);
            end else begin
                chk("idle_ram_en", {63'd0, ram_en}, 64'd0);
            end
            if (rd_resp_val && !prev_val) rise_cyc = cyc;
            prev_val = rd_resp_val;
            if (rd_resp_val && rd_resp_rdy) begin
                if (exp_q.size() != 0) begin
                    last_pop = exp_q[0].data;
                    void'(exp_q.pop_front());
                end
                pop_cnt++;
                pop_cyc_q.push_back(cyc);
            end
            if (m_rd_fire) begin
                exp_q.push_back('{data: shadow[rd_req_addr], due: cyc + 3});
                rd_fire_cnt++;
                acc_cyc = cyc;
            end
            if (m_wr_fire) shadow[wr_req_addr] = merge(shadow[wr_req_addr], wr_req_data, wr_req_mask);
            if (m_rd_ok && wr_req_val) prefer_rd = !prefer_rd;
            grant_log.push_back(m_wr_fire ? 1 : (m_rd_fire ? 2 : 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        logic got;
        got = 1'b0;
        wr_req_val = 1'b1; wr_req_addr = a; wr_req_data = d; wr_req_mask = m;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = wr_req_rdy;
            tick();
        end
        if (!got) chk("wr_timeout", 64'd0, 64'd1);
        wr_req_val = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        logic got;
        got = 1'b0;
        rd_req_val = 1'b1; rd_req_addr = a;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = rd_req_rdy;
            tick();
        end
        if (!got) chk("rd_timeout", 64'd0, 64'd1);
        rd_req_val = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        rd_resp_rdy = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    int base_fire, base_pop;

    initial begin
        for (int i = 0; i < DEP; i++) begin
            ram_mem[i] = '0;
            shadow[i]  = '0;
        end
        ram_s1 = '0; ram_dout = '0;
        prefer_rd = 1'b0; prev_val = 1'b0; last_pop = '0;
        wr_req_val = 1'b0; wr_req_addr = '0; wr_req_data = '0; wr_req_mask = '0;
        rd_req_val = 1'b0; rd_req_addr = '0; rd_resp_rdy = 1'b1;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("reset_resp_val", {63'd0, rd_resp_val}, 64'd0);
        chk("reset_wr_rdy", {63'd0, wr_req_rdy}, 64'd0);
        chk("reset_rd_rdy", {63'd0, rd_req_rdy}, 64'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        tick();

        // Prefill, then a single read of addr 5 with latency check.
        for (int i = 0; i < 16; i++) do_write(AW'(i), {$urandom, $urandom}, 8'hFF);
        do_write(9'd5, 64'hA5A5, 8'hFF);
        tick();
        do_read(9'd5);
        repeat (6) tick();
        chk("single_data", last_pop, 64'hA5A5);
        chk("single_latency", 64'(rise_cyc - acc_cyc), 64'd3);

        // Streaming reads of 0..15.
        base_fire = rd_fire_cnt;
        pop_cyc_q.delete();
        rd_req_val = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_req_addr = AW'(i);
            tick();
        end
        rd_req_val = 1'b0;
        repeat (6) tick();
        chk("stream_accepts", 64'(rd_fire_cnt - base_fire), 64'd16);
        chk("stream_pops", 64'(pop_cyc_q.size()), 64'd16);
        if (pop_cyc_q.size() == 16)
            chk("stream_back_to_back", 64'(pop_cyc_q[15] - pop_cyc_q[0]), 64'd15);

        // Backpressure: only BD reads accepted while the consumer stalls.
        base_fire = rd_fire_cnt;
        base_pop  = pop_cnt;
        rd_resp_rdy = 1'b0;
        rd_req_val  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rd_req_addr = AW'(i + 3);
            tick();
        end
        chk("bp_accepts", 64'(rd_fire_cnt - base_fire), 64'(BD));
        rd_resp_rdy = 1'b1;
        for (int n = 0; n < 20 && (rd_fire_cnt - base_fire) == BD; n++) tick();
        chk("bp_resume", 64'((rd_fire_cnt - base_fire) > BD), 64'd1);
        rd_req_val = 1'b0;
        drain(20);
        chk("bp_no_loss", 64'(pop_cnt - base_pop), 64'(rd_fire_cnt - base_fire));

        // Contention: both sides held for 6 cycles.
        grant_log.delete();
        wr_req_val = 1'b1; wr_req_addr = 9'd20; wr_req_data = 64'h0123_4567_89AB_CDEF; wr_req_mask = 8'hFF;
        rd_req_val = 1'b1; rd_req_addr = 9'd21;
        repeat (6) tick();
        wr_req_val = 1'b0; rd_req_val = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size())
                chk($sformatf("contend_grant%0d", i), 64'(grant_log[i]), (i % 2 == 0) ? 64'd1 : 64'd2);
        end
        drain(20);

        // Byte-masked merge.
        do_write(9'd9, 64'h1111_1111_1111_1111, 8'hFF);
        do_write(9'd9, 64'h0000_0000_0000_00FF, 8'h01);
        do_write(9'd10, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00);
        do_read(9'd9);
        repeat (6) tick();
        chk("merge_data", last_pop, 64'h1111_1111_1111_11FF);

        // Reset mid-flight.
        rd_resp_rdy = 1'b1;
        base_fire = rd_fire_cnt;
        rd_req_val = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_req_addr = AW'(i);
            tick();
        end
        rd_req_val = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("midrst_resp_val", {63'd0, rd_resp_val}, 64'd0);
        chk("midrst_rd_rdy", {63'd0, rd_req_rdy}, 64'd0);
        chk("midrst_wr_rdy", {63'd0, wr_req_rdy}, 64'd0);
        chk("midrst_accepts", 64'(rd_fire_cnt - base_fire), 64'd3);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        base_pop = pop_cnt;
        repeat (6) tick();
        chk("midrst_no_stale", 64'(pop_cnt - base_pop), 64'd0);
        do_read(9'd5);
        repeat (6) tick();
        chk("midrst_data", last_pop, 64'hA5A5);
        chk("midrst_latency", 64'(rise_cyc - acc_cyc), 64'd3);

        // Randomized mix until 50 reads have been accepted.
        base_fire = rd_fire_cnt;
        for (int n = 0; n < 2000 && (rd_fire_cnt - base_fire) < 50; n++) begin
            rd_resp_rdy = 1'($urandom_range(0, 1));
            rd_req_val  = 1'($urandom_range(0, 1));
            rd_req_addr = AW'($urandom_range(0, 31));
            wr_req_val  = ($urandom_range(0, 3) == 0);
            wr_req_addr = AW'($urandom_range(0, 31));
            wr_req_data = {$urandom, $urandom};
            wr_req_mask = MW'($urandom);
            tick();
        end
        rd_req_val = 1'b0;
        wr_req_val = 1'b0;
        chk("rand_accepts", 64'((rd_fire_cnt - base_fire) >= 50), 64'd1);
        drain(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
